// File: rtl/serial_cmd_master.sv
// Serial command initiator: sends cmd + 32-bit operand MSB first on uart_tx, assembles the 4-byte reply.
// First tx_start 2 cycles after accept; req_ready only in IDLE, byte strobes paced by tx_ready.
module serial_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_W           = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        rsp_mismatch,
  output logic        busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_rcv,
  input  logic [7:0]  rx_data
);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [39:0]       shreg_q, shreg_d;
  logic [2:0]        tx_cnt_q, tx_cnt_d;
  logic [1:0]        rx_cnt_q, rx_cnt_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic [31:0]       rsp_sh_q, rsp_sh_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [31:0]       data_q, data_d;
  logic              last_tx_ready_q, last_tx_ready_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              rsp_mismatch_q, rsp_mismatch_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_fall;
  logic [31:0]       word;

  // Reply is compared against what the target is expected to echo for each command.
  function automatic logic echo_bad(input logic [7:0] cmd, input logic [31:0] sent,
                                    input logic [31:0] rep);
    logic bad;
    case (cmd)
      8'd1, 8'd2: bad = (rep != sent);
      8'd4, 8'd6: bad = 1'b0;
      default:    bad = (rep != {24'd0, cmd});
    endcase
    echo_bad = bad;
  endfunction

  always_comb begin
    state_d         = state_q;
    shreg_d         = shreg_q;
    tx_cnt_d        = tx_cnt_q;
    rx_cnt_d        = rx_cnt_q;
    timer_d         = timer_q;
    rsp_sh_d        = rsp_sh_q;
    cmd_d           = cmd_q;
    data_d          = data_q;
    last_tx_ready_d = tx_ready;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = rsp_data_q;
    rsp_timeout_d   = 1'b0;
    rsp_mismatch_d  = 1'b0;
    tx_start_d      = tx_start_q;
    tx_data_d       = tx_data_q;
    tx_fall         = !tx_ready && last_tx_ready_q;
    word            = {rsp_sh_q[23:0], rx_data};

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          shreg_d  = {req_cmd, req_data};
          tx_cnt_d = 3'd5;
          cmd_d    = req_cmd;
          data_d   = req_data;
          state_d  = SEND;
        end
      end
      SEND: begin
        tx_data_d = shreg_q[39:32];
        // A strobe is only dropped by the uart's own busy edge, so each byte is sent once.
        if (tx_fall) begin
          tx_start_d = 1'b0;
          shreg_d    = {shreg_q[31:0], 8'd0};
          tx_cnt_d   = tx_cnt_q - 3'd1;
          if (tx_cnt_q == 3'd1) begin
            state_d  = RECV;
            rx_cnt_d = 2'd0;
            timer_d  = '0;
            rsp_sh_d = '0;
          end
        end else if (tx_ready && !tx_start_q) begin
          tx_start_d = 1'b1;
        end
      end
      RECV: begin
        if (rx_rcv) begin
          rsp_sh_d = word;
          rx_cnt_d = rx_cnt_q + 2'd1;
          timer_d  = '0;
          if (rx_cnt_q == 2'd3) begin
            state_d        = DONE;
            rsp_valid_d    = 1'b1;
            rsp_data_d     = word;
            rsp_mismatch_d = echo_bad(cmd_q, data_q, word);
          end
        end else if (timer_q == TO_LAST) begin
          state_d       = DONE;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = !req_ready_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      shreg_q         <= '0;
      tx_cnt_q        <= '0;
      rx_cnt_q        <= '0;
      timer_q         <= '0;
      rsp_sh_q        <= '0;
      cmd_q           <= '0;
      data_q          <= '0;
      last_tx_ready_q <= 1'b0;
      req_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_timeout_q   <= 1'b0;
      rsp_mismatch_q  <= 1'b0;
      tx_start_q      <= 1'b0;
      tx_data_q       <= '0;
    end else begin
      state_q         <= state_d;
      shreg_q         <= shreg_d;
      tx_cnt_q        <= tx_cnt_d;
      rx_cnt_q        <= rx_cnt_d;
      timer_q         <= timer_d;
      rsp_sh_q        <= rsp_sh_d;
      cmd_q           <= cmd_d;
      data_q          <= data_d;
      last_tx_ready_q <= last_tx_ready_d;
      req_ready_q     <= req_ready_d;
      busy_q          <= busy_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_timeout_q   <= rsp_timeout_d;
      rsp_mismatch_q  <= rsp_mismatch_d;
      tx_start_q      <= tx_start_d;
      tx_data_q       <= tx_data_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign rsp_mismatch = rsp_mismatch_q;
  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;

endmodule
